// File: rtl/sipo_packer.sv
// sipo_packer: serial-to-parallel bit packer with partial-word flush and a small output FIFO.
// Optional build macro SIPO_PACKER_PARITY_EN adds word_par_o (even parity of the head word).
module sipo_packer #(
    parameter int  WORD_W = 8,
    parameter int  DEPTH  = 2,
    localparam int LEN_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_i,
    input  logic              bit_valid_i,
    output logic              bit_ready_o,
    input  logic              msb_first_i,
    input  logic              flush_i,
    output logic [WORD_W-1:0] word_o,
    output logic [LEN_W-1:0]  word_len_o,
    output logic              word_valid_o,
    input  logic              word_ready_i
`ifdef SIPO_PACKER_PARITY_EN
    ,
    output logic              word_par_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WORD_W);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_nxt;
    logic [LEN_W-1:0]  fill_q;
    logic [LEN_W-1:0]  fill_nxt;
    logic              msb_q;
    logic              flush_pend_q;
    logic              flush_pend_nxt;

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [WORD_W-1:0] mem_word [DEPTH];
    logic [LEN_W-1:0]  mem_len  [DEPTH];
`ifdef SIPO_PACKER_PARITY_EN
    logic              mem_par  [DEPTH];
`endif

    logic              fifo_full;
    logic              fifo_empty;
    logic              bit_acc;
    logic              order_msb;
    logic [LEN_W-1:0]  bit_pos;
    logic              full_word;
    logic              flush_req;
    logic              push;
    logic              pop;

    assign fifo_full    = (count_q == FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign bit_ready_o  = !fifo_full && !flush_pend_q;
    assign bit_acc      = bit_valid_i && bit_ready_o;
    assign pop          = !fifo_empty && word_ready_i;

    // Bit order is latched with the first bit of a word; later changes wait for the next word.
    always_comb begin
        order_msb = (fill_q == '0) ? msb_first_i : msb_q;
        bit_pos   = order_msb ? (FULL_LEN - LEN_W'(1) - fill_q) : fill_q;
        acc_nxt   = acc_q;
        fill_nxt  = fill_q;
        if (bit_acc) begin
            acc_nxt  = acc_q | ({{(WORD_W-1){1'b0}}, bit_i} << bit_pos);
            fill_nxt = fill_q + LEN_W'(1);
        end
        full_word      = (fill_nxt == FULL_LEN);
        flush_req      = (flush_i || flush_pend_q) && (fill_nxt != '0) && !full_word;
        push           = full_word || (flush_req && !fifo_full);
        flush_pend_nxt = flush_req && fifo_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            fill_q       <= '0;
            msb_q        <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            if (bit_acc && (fill_q == '0)) begin
                msb_q <= msb_first_i;
            end
            flush_pend_q <= flush_pend_nxt;
            if (push) begin
                acc_q  <= '0;
                fill_q <= '0;
            end else begin
                acc_q  <= acc_nxt;
                fill_q <= fill_nxt;
            end
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_word[i] <= '0;
                mem_len[i]  <= '0;
`ifdef SIPO_PACKER_PARITY_EN
                mem_par[i]  <= 1'b0;
`endif
            end
        end else if (push) begin
            mem_word[wr_ptr_q] <= acc_nxt;
            mem_len[wr_ptr_q]  <= fill_nxt;
`ifdef SIPO_PACKER_PARITY_EN
            mem_par[wr_ptr_q]  <= ^acc_nxt;
`endif
        end
    end

    assign word_valid_o = !fifo_empty;
    assign word_o       = fifo_empty ? '0 : mem_word[rd_ptr_q];
    assign word_len_o   = fifo_empty ? '0 : mem_len[rd_ptr_q];
`ifdef SIPO_PACKER_PARITY_EN
    assign word_par_o   = fifo_empty ? 1'b0 : mem_par[rd_ptr_q];
`endif

endmodule

// File: tb/tb_sipo_packer.sv
// Self-checking bench for sipo_packer: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the packer and its FIFO.
`timescale 1ns/1ps
module tb_sipo_packer;

    localparam int WORD_W = 8;
    localparam int DEPTH  = 2;
    localparam int LEN_W  = $clog2(WORD_W + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bit_i;
    logic              bit_valid_i;
    logic              bit_ready_o;
    logic              msb_first_i;
    logic              flush_i;
    logic [WORD_W-1:0] word_o;
    logic [LEN_W-1:0]  word_len_o;
    logic              word_valid_o;
    logic              word_ready_i;
`ifdef SIPO_PACKER_PARITY_EN
    logic              word_par_o;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WORD_W-1:0] word;
        int                len;
    } entry_t;

    entry_t m_q[$];
    bit     m_bits[$];
    bit     m_msb;
    bit     m_pend;

    int seq[8] = '{1, 0, 1, 1, 0, 0, 1, 0};

    always #5 clk = ~clk;

    sipo_packer #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .bit_ready_o  (bit_ready_o),
        .msb_first_i  (msb_first_i),
        .flush_i      (flush_i),
        .word_o       (word_o),
        .word_len_o   (word_len_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i)
`ifdef SIPO_PACKER_PARITY_EN
        ,
        .word_par_o   (word_par_o)
`endif
    );

    function automatic logic [WORD_W-1:0] build_word(input bit b[$], input bit msb);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < b.size(); k++) begin
            if (msb) w[WORD_W-1-k] = b[k];
            else     w[k] = b[k];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_bits.delete();
        m_msb  = 1'b0;
        m_pend = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic step();
        bit     acc_b, pop_b, do_push;
        entry_t e;
        acc_b   = bit_valid_i && (m_q.size() < DEPTH) && !m_pend;
        pop_b   = (m_q.size() > 0) && word_ready_i;
        do_push = 1'b0;
        if (acc_b) begin
            if (m_bits.size() == 0) m_msb = msb_first_i;
            m_bits.push_back(bit_i);
        end
        if (m_bits.size() == WORD_W) begin
            do_push = 1'b1;
        end else if ((flush_i || m_pend) && m_bits.size() > 0) begin
            if (m_q.size() < DEPTH) begin
                do_push = 1'b1;
                m_pend  = 1'b0;
            end else begin
                m_pend = 1'b1;
            end
        end
        e.word = build_word(m_bits, m_msb);
        e.len  = m_bits.size();
        if (pop_b) void'(m_q.pop_front());
        if (do_push) begin
            m_q.push_back(e);
            m_bits.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input bit fl);
        bit_valid_i = 1'b1;
        bit_i       = b;
        flush_i     = fl;
        step();
        bit_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bit_i = 0; bit_valid_i = 0; msb_first_i = 0; flush_i = 0; word_ready_i = 0;
        model_reset();
        #12;
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", word_valid_o); end
        checks++; if (word_o !== '0) begin errors++; $display("FAIL reset_word: got %h expected 0", word_o); end
        checks++; if (word_len_o !== '0) begin errors++; $display("FAIL reset_len: got %0d expected 0", word_len_o); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bit_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bit_ready_o); end
    endtask

    task automatic test_lsb();
        word_ready_i = 1'b1; msb_first_i = 1'b0;
        for (int k = 0; k < 7; k++) send_bit(seq[k][0], 1'b0);
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL lsb_early_valid: got %b expected 0", word_valid_o); end
        send_bit(seq[7][0], 1'b0);
        checks++; if (word_valid_o !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %b expected 1", word_valid_o); end
        checks++; if (word_o !== 8'h4D) begin errors++; $display("FAIL lsb_word: got %h expected 4d", word_o); end
        checks++; if (word_len_o !== LEN_W'(8)) begin errors++; $display("FAIL lsb_len: got %0d expected 8", word_len_o); end
        step();
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL lsb_one_cycle: got %b expected 0", word_valid_o); end
    endtask

    task automatic test_msb();
        word_ready_i = 1'b1; msb_first_i = 1'b1;
        for (int k = 0; k < 8; k++) send_bit(seq[k][0], 1'b0);
        checks++; if (word_o !== 8'hB2 || word_len_o !== LEN_W'(8)) begin
            errors++; $display("FAIL msb_word: got %h/%0d expected b2/8", word_o, word_len_o); end
        step();
        msb_first_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) msb_first_i = 1'b0;
            send_bit(seq[k][0], 1'b0);
        end
        checks++; if (word_o !== 8'hB2 || word_valid_o !== 1'b1) begin
            errors++; $display("FAIL msb_toggle: got %h valid %b expected b2 valid 1", word_o, word_valid_o); end
        step();
        msb_first_i = 1'b0;
    endtask

    task automatic test_flush();
        word_ready_i = 1'b1; msb_first_i = 1'b0;
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
        do_flush();
        checks++; if (word_valid_o !== 1'b1 || word_o !== 8'h03 || word_len_o !== LEN_W'(3)) begin
            errors++; $display("FAIL flush_lsb: got %b %h/%0d expected 1 03/3", word_valid_o, word_o, word_len_o); end
        step();
        msb_first_i = 1'b1;
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
        do_flush();
        checks++; if (word_valid_o !== 1'b1 || word_o !== 8'hC0 || word_len_o !== LEN_W'(3)) begin
            errors++; $display("FAIL flush_msb: got %b %h/%0d expected 1 c0/3", word_valid_o, word_o, word_len_o); end
        step();
        msb_first_i = 1'b0;
        do_flush();
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty: got valid %b expected 0", word_valid_o); end
        // Flush coinciding with the completing bit yields only the full word.
        for (int k = 0; k < 7; k++) send_bit(1, 0);
        send_bit(0, 1);
        checks++; if (word_o !== 8'h7F || word_len_o !== LEN_W'(8)) begin
            errors++; $display("FAIL flush_full: got %h/%0d expected 7f/8", word_o, word_len_o); end
        step();
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL flush_full_extra: got valid %b expected 0", word_valid_o); end
        send_bit(1, 0);
        send_bit(1, 1);
        checks++; if (word_o !== 8'h03 || word_len_o !== LEN_W'(2)) begin
            errors++; $display("FAIL flush_same_bit: got %h/%0d expected 03/2", word_o, word_len_o); end
        step();
    endtask

    task automatic test_back_to_back();
        bit src[24];
        bit first8[$];
        int idx = 0, n_acc = 0, words_seen = 0;
        bit acc;
        for (int i = 0; i < 24; i++) src[i] = 1'($urandom);
        for (int i = 0; i < 8; i++) first8.push_back(src[i]);
        word_ready_i = 1'b0; msb_first_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bit_valid_i = 1'b1;
            bit_i = src[idx];
            acc = bit_ready_o;
            step();
            if (acc) begin
                idx++; n_acc++;
                if (n_acc == 16) begin
                    checks++; if (bit_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_after16: got %b expected 0", bit_ready_o); end
                end
            end
        end
        checks++; if (n_acc != 16) begin errors++; $display("FAIL bp_accepted: got %0d expected 16", n_acc); end
        checks++; if (word_o !== build_word(first8, 1'b0) || word_len_o !== LEN_W'(8)) begin
            errors++; $display("FAIL bp_head_held: got %h/%0d expected %h/8", word_o, word_len_o, build_word(first8, 1'b0)); end
        word_ready_i = 1'b1;
        for (int c = 0; c < 80 && (idx < 24 || m_q.size() > 0); c++) begin
            bit_valid_i = (idx < 24);
            bit_i = (idx < 24) ? src[idx] : 1'b0;
            acc = bit_valid_i && bit_ready_o;
            if (word_valid_o) begin
                words_seen++;
                checks++; if (m_q.size() == 0 || word_o !== m_q[0].word || word_len_o !== LEN_W'(m_q[0].len)) begin
                    errors++; $display("FAIL bp_drain_word: got %h/%0d", word_o, word_len_o); end
            end
            step();
            if (acc) idx++;
        end
        bit_valid_i = 1'b0;
        checks++; if (idx != 24 || words_seen != 3 || m_q.size() != 0) begin
            errors++; $display("FAIL bp_drain_done: got bits %0d words %0d expected 24 bits 3 words", idx, words_seen); end
    endtask

    task automatic test_flush_full();
        word_ready_i = 1'b0; msb_first_i = 1'b0;
        for (int k = 0; k < 8; k++) send_bit(1, 0);
        for (int k = 0; k < 5; k++) send_bit(seq[k][0], 0);
        do_flush();
        checks++; if (bit_ready_o !== 1'b0) begin errors++; $display("FAIL ff_ready: got %b expected 0", bit_ready_o); end
        do_flush();
        word_ready_i = 1'b1;
        step();
        checks++; if (word_o !== 8'h0D || word_len_o !== LEN_W'(5)) begin
            errors++; $display("FAIL ff_partial: got %h/%0d expected 0d/5", word_o, word_len_o); end
        step();
        checks++; if (word_valid_o !== 1'b0 || bit_ready_o !== 1'b1) begin
            errors++; $display("FAIL ff_drained: got valid %b ready %b expected 0 1", word_valid_o, bit_ready_o); end
    endtask

    task automatic test_reset_mid();
        bit fresh[$];
        word_ready_i = 1'b0; msb_first_i = 1'b0;
        for (int k = 0; k < 8; k++) send_bit(1, 0);
        for (int k = 0; k < 4; k++) send_bit(1, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (word_valid_o !== 1'b0 || word_o !== '0 || word_len_o !== '0) begin
            errors++; $display("FAIL rst_mid: got %b %h/%0d expected 0 0/0", word_valid_o, word_o, word_len_o); end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        word_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) fresh.push_back(1'($urandom));
        for (int k = 0; k < 8; k++) send_bit(fresh[k], 0);
        checks++; if (word_o !== build_word(fresh, 1'b0) || word_len_o !== LEN_W'(8)) begin
            errors++; $display("FAIL rst_clean_word: got %h/%0d expected %h/8", word_o, word_len_o, build_word(fresh, 1'b0)); end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            bit_valid_i  = ($urandom_range(0, 3) != 0);
            bit_i        = 1'($urandom);
            msb_first_i  = 1'($urandom);
            flush_i      = ($urandom_range(0, 9) == 0);
            word_ready_i = ($urandom_range(0, 2) != 0);
            checks++; if (bit_ready_o !== ((m_q.size() < DEPTH) && !m_pend)) begin
                errors++; $display("FAIL rnd_ready: cycle %0d got %b", c, bit_ready_o); end
            checks++; if (word_valid_o !== (m_q.size() > 0)) begin
                errors++; $display("FAIL rnd_valid: cycle %0d got %b expected %b", c, word_valid_o, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                checks++; if (word_o !== m_q[0].word || word_len_o !== LEN_W'(m_q[0].len)) begin
                    errors++; $display("FAIL rnd_word: cycle %0d got %h/%0d expected %h/%0d", c, word_o, word_len_o, m_q[0].word, m_q[0].len); end
`ifdef SIPO_PACKER_PARITY_EN
                checks++; if (word_par_o !== ^m_q[0].word) begin
                    errors++; $display("FAIL rnd_par: cycle %0d got %b expected %b", c, word_par_o, ^m_q[0].word); end
`endif
            end
            step();
        end
        bit_valid_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lsb();
        test_msb();
        test_flush();
        test_back_to_back();
        test_flush_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
